// File: rtl/motoro3_pkg.sv
// State encoding and default sizing shared by the motor PWM generator family.
package motoro3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON      = 2'd1,
    OFF     = 2'd2,
    FULL_ON = 2'd3
  } pwm_state_t;

  localparam int DEF_CNT_W   = 13;
  localparam int DEF_MIN_ON  = 32;
  localparam int DEF_MIN_OFF = 32;

endpackage

// File: rtl/motoro3_pwm_clamp.sv
// Runt-pulse clamp: maps a requested duty/period pair onto the PWM state that
// a fresh period should start in, plus the duty that state actually produces.
module motoro3_pwm_clamp
  import motoro3_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] period,
  output pwm_state_t       nextState,
  output logic [CNT_W-1:0] effDuty
);

  localparam logic [CNT_W-1:0] MinOn  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MinOff = CNT_W'(MIN_OFF);

  always_comb begin
    nextState = ON;
    effDuty   = duty;
    if (period == '0) begin
      nextState = IDLE;
      effDuty   = '0;
    end else if (duty == '0 || duty < MinOn) begin
      nextState = OFF;
      effDuty   = '0;
    end else if (duty >= period || (period - duty) < MinOff) begin
      // period - duty is only evaluated once duty < period, so it cannot wrap
      nextState = FULL_ON;
      effDuty   = period;
    end
  end

endmodule

// File: rtl/motoro3_pwm_gen_param.sv
// Runtime-programmable motor PWM with shadowed duty/period and runt clamping.
// Optional soft-start ramp is compiled in with MOTORO3_PWM_SOFTSTART_EN.
module motoro3_pwm_gen_param
  import motoro3_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF
`ifdef MOTORO3_PWM_SOFTSTART_EN
  , parameter int RAMP_STEP = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aE,
  input  logic             bE,
  input  logic             cE,
  input  logic             m3cntLast1,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] period,
  output logic             pwm,
  output logic             pwm_start,
  output logic             full_on
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_state_t       state, nextState, clampState;
  logic [CNT_W-1:0] cnt, dutyS, periodS;
  logic [CNT_W-1:0] loadDuty, effDuty;
  logic             en, periodEnd, load;

  assign en        = aE | bE | cE;
  assign periodEnd = (state != IDLE) && (cnt == periodS - ONE);
  // A coincident strobe and period end collapse into this single load
  assign load      = en && ((state == IDLE) || periodEnd || m3cntLast1);

`ifdef MOTORO3_PWM_SOFTSTART_EN
  logic [CNT_W-1:0] ramp, rampBase;
  logic [CNT_W:0]   rampSum;

  assign rampBase = (state == IDLE) ? '0 : ramp;
  assign rampSum  = {1'b0, rampBase} + (CNT_W+1)'(RAMP_STEP);
  assign loadDuty = (rampSum > {1'b0, duty}) ? duty : rampSum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp <= '0;
    end else if (!en) begin
      ramp <= '0;
    end else if (load) begin
      ramp <= loadDuty;
    end
  end
`else
  assign loadDuty = duty;
`endif

  motoro3_pwm_clamp #(
    .CNT_W  (CNT_W),
    .MIN_ON (MIN_ON),
    .MIN_OFF(MIN_OFF)
  ) uClamp (
    .duty     (loadDuty),
    .period   (period),
    .nextState(clampState),
    .effDuty  (effDuty)
  );

  always_comb begin
    nextState = state;
    if (!en) begin
      nextState = IDLE;
    end else if (load) begin
      nextState = clampState;
    end else if (state == ON && cnt == dutyS - ONE) begin
      nextState = OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dutyS     <= '0;
      periodS   <= '0;
      pwm       <= 1'b0;
      pwm_start <= 1'b0;
      full_on   <= 1'b0;
    end else begin
      state <= nextState;
      if (!en || load || state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
      if (load) begin
        dutyS   <= effDuty;
        periodS <= period;
      end
      // Gate outputs trail the state by one edge; losing all enables kills them at once
      pwm       <= en && (state == ON || state == FULL_ON);
      full_on   <= en && (state == FULL_ON);
      pwm_start <= load && (clampState != IDLE);
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_gen_param.sv
// Scoreboarded bench for motoro3_pwm_gen_param against a per-period pulse model.
`timescale 1ns/1ps
module tb_motoro3_pwm_gen_param;

`ifdef MOTORO3_PWM_SOFTSTART_EN
  localparam int TB_MIN_ON = 0;
`else
  localparam int TB_MIN_ON = 32;
`endif
  localparam int TB_MIN_OFF   = 32;
  localparam int TB_RAMP_STEP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        aE, bE, cE, m3cntLast1;
  logic [12:0] duty, period;
  logic        pwm, pwm_start, full_on;

  motoro3_pwm_gen_param #(.MIN_ON(TB_MIN_ON)) dut (
    .clk       (clk),
    .rst       (rst),
    .aE        (aE),
    .bE        (bE),
    .cE        (cE),
    .m3cntLast1(m3cntLast1),
    .duty      (duty),
    .period    (period),
    .pwm       (pwm),
    .pwm_start (pwm_start),
    .full_on   (full_on)
  );

  always #5 clk = ~clk;

  logic [2:0] q[$];
  logic [2:0] expv;
  logic [2:0] lastExp;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected {pwm,pwm_start,full_on} per clock edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      expv = q.pop_front();
      checks = checks + 1;
      if ({pwm, pwm_start, full_on} !== expv) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d got pwm/start/full=%b required %b",
                 cyc, {pwm, pwm_start, full_on}, expv);
      end
    end
  end

  // Reference model: a period is an on-time followed by an off-time
  bit mActive, mFull;
  int mPer, mOn, mT, mRamp;

  task automatic modelReset();
    mActive = 0; mFull = 0; mPer = 0; mOn = 0; mT = 0; mRamp = 0;
  endtask

  task automatic step();
    bit         enable, ld;
    logic [2:0] e;
    int         d, p;
    enable = aE | bE | cE;
    p      = int'(period);
    ld     = enable && (!mActive || mT == mPer - 1 || m3cntLast1);
    e[2]   = enable && mActive && (mT < mOn);
    e[1]   = ld && (p != 0);
    e[0]   = enable && mActive && mFull;
    if (!enable) begin
      mActive = 0; mT = 0; mRamp = 0;
    end else if (ld) begin
      d = int'(duty);
`ifdef MOTORO3_PWM_SOFTSTART_EN
      d = (mActive ? mRamp : 0) + TB_RAMP_STEP;
      if (d > int'(duty)) d = int'(duty);
      mRamp = d;
`endif
      if (p == 0) begin
        mActive = 0;
      end else begin
        mActive = 1; mPer = p; mT = 0; mFull = 0;
        if (d == 0 || d < TB_MIN_ON) mOn = 0;
        else if (d >= p || p - d < TB_MIN_OFF) begin mOn = p; mFull = 1; end
        else mOn = d;
      end
    end else begin
      mT++;
    end
    @(posedge clk);
    q.push_back(e);
    lastExp = e;
    #1;
  endtask

  task automatic run(input int n, input bit rndStrobe);
    for (int i = 0; i < n; i++) begin
      if (rndStrobe) m3cntLast1 = ($urandom_range(0, 149) == 0);
      step();
    end
    m3cntLast1 = 1'b0;
  endtask

  task automatic runUntilT(input int t);
    for (int i = 0; i < 2000 && !(mActive && mT == t); i++) step();
  endtask

  int bd[10] = '{100, 32, 31, 368, 369, 400, 500, 0, 40, 20};
  int bp[10] = '{400, 400, 400, 400, 400, 400, 400, 400, 80, 0};

  initial begin
    rst = 1'b1; aE = 0; bE = 0; cE = 0; m3cntLast1 = 0; duty = '0; period = '0;
    lastExp = '0;
    modelReset();
    repeat (3) begin @(posedge clk); q.push_back(3'b000); end
    #1 rst = 1'b0;

    aE = 1; duty = 13'd100; period = 13'd400;
    run(1205, 0);

    // Asynchronous reset while the gate is high
    for (int i = 0; i < 1000 && !lastExp[2]; i++) step();
    rst = 1'b1;
    #1;
    if (pwm !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async reset cyc=%0d pwm=%b required 0", cyc, pwm);
    end
    if (pwm_start !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async reset cyc=%0d pwm_start=%b required 0", cyc, pwm_start);
    end
    q.delete();
    q.push_back(3'b000);
    repeat (2) begin @(posedge clk); q.push_back(3'b000); end
    #1 rst = 1'b0;
    modelReset();

    duty = 13'd20;  run(810, 0);
    if (pwm !== lastExp[2]) begin
      errors = errors + 1;
      $display("FAIL min-on clamp cyc=%0d pwm=%b required %b", cyc, pwm, lastExp[2]);
    end
    duty = 13'd390; run(810, 0);
    if (full_on !== lastExp[0] || pwm !== lastExp[2]) begin
      errors = errors + 1;
      $display("FAIL min-off clamp cyc=%0d pwm/full=%b%b required %b%b",
               cyc, pwm, full_on, lastExp[2], lastExp[0]);
    end

    duty = 13'd100; run(405, 0);
    runUntilT(50);
    duty = 13'd200;
    run(900, 0);

    runUntilT(250);
    m3cntLast1 = 1'b1; duty = 13'd150;
    step();
    m3cntLast1 = 1'b0;
    run(20, 0);
    aE = 0; bE = 0; cE = 0;
    run(5, 0);
    cE = 1;
    run(420, 0);

    for (int k = 0; k < 10; k++) begin
      duty = 13'(bd[k]); period = 13'(bp[k]);
      run(2 * bp[k] + 10, 0);
    end

    for (int s = 0; s < 40; s++) begin
      int pick;
      period = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 450));
      duty   = 13'($urandom_range(0, int'(period) + 40));
      pick   = $urandom_range(0, 9);
      {aE, bE, cE} = (pick == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run($urandom_range(50, 700), 1);
    end

    @(negedge clk);
    #1;
    if (checks == 0) begin
      errors = errors + 1;
      $display("FAIL no output checks were performed");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/motoro3_pwm_gen_param.md
Name: motoro3_pwm_gen_param

Overview:
- Parametrised successor to the fixed-duty motor PWM generator in the 3-phase driver path.
- Runtime duty and period inputs; shadow registers commit only at period boundaries or at the commutation strobe.
- Minimum-pulse clamping protects MOSFETs from runt pulses shorter than ~3 us.
- Sits between the commutation sequencer (m3cnt / m3cntLast1 source) and the phase gate drivers; one PWM output is shared by all enabled phases.

Parameters:
- CNT_W, 13, width of period/duty/counter.
- MIN_ON, 32, minimum on-pulse in clk cycles; shorter requests become 0 % duty.
- MIN_OFF, 32, minimum off-pulse in clk cycles; shorter requests become 100 % duty.
- RAMP_STEP, 16, duty increment per period when soft-start is compiled in.

Ports:
- clk  input  1  system clock, 10 MHz, posedge only.
- rst  input  1  asynchronous active-high reset.
- aE  input  1  phase A enable.
- bE  input  1  phase B enable.
- cE  input  1  phase C enable.
- m3cntLast1  input  1  commutation strobe, one cycle wide.
- duty  input  CNT_W  requested on-time in cycles.
- period  input  CNT_W  requested PWM period in cycles.
- pwm  output  1  registered PWM gate output.
- pwm_start  output  1  one-cycle pulse on the first cycle of each period.
- full_on  output  1  high while the block is in FULL_ON.

Behaviour:
- Single clock `clk`, posedge only. Reset is asynchronous and active-high on `rst`.
- Reset values: pwm=0, pwm_start=0, full_on=0, state=IDLE, cnt=0, duty_s=0, period_s=0.
- States: IDLE, ON, OFF, FULL_ON. Free-running counter cnt, CNT_W bits.
- en = aE|bE|cE.
- !en in any state: next state IDLE, pwm=0, cnt=0. This overrides all other conditions.
- Shadow commit: duty_s<=duty and period_s<=period, taken at a "load" edge.
  - A load edge is any of: IDLE with en=1; cnt==period_s-1 in ON/OFF/FULL_ON; m3cntLast1=1 with en=1.
  - m3cntLast1 additionally forces cnt=0, i.e. a restart of the period.
- Clamp, evaluated on the values being committed:
  - period==0 -> IDLE.
  - duty<MIN_ON -> OFF (pwm=0 for the whole period).
  - duty>=period or period-duty<MIN_OFF -> FULL_ON.
  - else -> ON.
- ON: pwm=1. Move to OFF when cnt==duty_s-1.
- OFF: pwm=0. On cnt==period_s-1, do a load edge and re-enter per the clamp.
- FULL_ON: pwm=1, full_on=1.
- cnt increments each cycle in ON/OFF/FULL_ON. It wraps to 0 at period_s-1 or on m3cntLast1.
- pwm_start=1 on the cycle after every load edge that enters ON, OFF or FULL_ON.
- Latency: en rising at edge k commits the shadows at k; pwm reflects the new state after edge k+1.
- Simultaneous m3cntLast1 and period end: treated as one load. No double count, one pwm_start.
- duty/period changes mid-period are ignored until the next load edge, so no glitched pulses.
- Reset asserted mid-pulse: pwm drops to 0 asynchronously.

Optional Feature:
- Macro MOTORO3_PWM_SOFTSTART_EN.
- Defined:
  - An internal ramp register starts at 0 on reset and on IDLE.
  - At each load edge: ramp<=min(ramp+RAMP_STEP, duty). The clamp and duty_s use ramp instead of duty.
  - Ramp saturates at duty. If duty falls below ramp, ramp follows duty immediately.
- Undefined: duty is used directly. No ramp register is synthesised.

Decomposition:
- Package motoro3_pkg holds:
  - state encoding constants (IDLE=2'd0, ON=2'd1, OFF=2'd2, FULL_ON=2'd3);
  - default MIN_ON, MIN_OFF and CNT_W constants.
- One natural sub-module: motoro3_pwm_clamp. It is combinational: (duty, period, MIN_ON, MIN_OFF) -> next state and effective duty. It is shared with a future per-phase variant.

Test Plan:
- Reset, then en=1, duty=100, period=400: pwm high 100 cycles, low 300, repeating; pwm_start every 400 cycles.
- duty=20 (<MIN_ON), period=400: pwm stays 0 all period, full_on=0, pwm_start still pulses each 400 cycles.
- duty=390, period=400 (off=10<MIN_OFF): full_on=1, pwm constant 1.
- Mid-ON at cnt=50, change duty 100->200: current period keeps 100-cycle pulse; next period gives 200.
- m3cntLast1 at cnt=250: cnt restarts at 0, single pwm_start, new shadow values apply from the next cycle. Then drive {aE,bE,cE}=000: pwm=0 and IDLE next cycle.
- With MOTORO3_PWM_SOFTSTART_EN, duty=64, RAMP_STEP=16, MIN_ON=0: successive on-times 16, 32, 48, 64, 64.
